// File: rtl/demod_pkg.sv
// Shared types and arithmetic helpers for the FM demodulator conjugate
// multiplier. Imported by demod_conj_mult and complex_mult_dequant.
//   state_t    : FSM states of the pop / multiply / push sequence
//   wide_t     : signed working type wide enough for 2*DATA_WIDTH+1 sums
//                (DATA_WIDTH up to 64)
//   dequantize : signed divide by 2**frac_bits, truncating toward zero
//   narrow     : reduce to a signed width by saturation or wrap-around
package demod_pkg;

  localparam int unsigned WIDE_W = 129;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {
    S_READ,
    S_MULT,
    S_WRITE
  } state_t;

  // Negative values get 2**frac_bits-1 added before the arithmetic shift so
  // the result rounds toward zero like a true signed division.
  function automatic wide_t dequantize(input wide_t value, input int unsigned frac_bits);
    wide_t bias;
    bias = (wide_t'(1) <<< frac_bits) - wide_t'(1);
    if (value[WIDE_W-1]) begin
      return (value + bias) >>> frac_bits;
    end
    return value >>> frac_bits;
  endfunction

  // Result is sign-correct across the full wide_t; callers keep the low
  // 'width' bits.
  function automatic wide_t narrow(input wide_t value, input int unsigned width,
                                   input bit saturate);
    wide_t max_v;
    wide_t min_v;
    wide_t wrapped;
    max_v   = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    min_v   = -max_v - wide_t'(1);
    wrapped = (value <<< (WIDE_W - width)) >>> (WIDE_W - width);
    if (saturate) begin
      if (value > max_v) return max_v;
      if (value < min_v) return min_v;
      return value;
    end
    return wrapped;
  endfunction

endpackage

// File: rtl/complex_mult_dequant.sv
// Combinational back end of the conjugate multiplier: combines the four
// partial products into real/imag sums, dequantises and narrows them.
//   rr_i, ii_i, ri_i, ir_i : signed 2*DATA_WIDTH partial products
//   real_o, imag_o         : signed DATA_WIDTH results
module complex_mult_dequant
  import demod_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int CONJ       = 1,
  parameter int SATURATE   = 0
) (
  input  logic signed [2*DATA_WIDTH-1:0] rr_i,
  input  logic signed [2*DATA_WIDTH-1:0] ii_i,
  input  logic signed [2*DATA_WIDTH-1:0] ri_i,
  input  logic signed [2*DATA_WIDTH-1:0] ir_i,
  output logic signed [DATA_WIDTH-1:0]   real_o,
  output logic signed [DATA_WIDTH-1:0]   imag_o
);

  localparam int SW = 2 * DATA_WIDTH + 1;

  logic signed [SW-1:0] sum_r;
  logic signed [SW-1:0] sum_i;

  always_comb begin
    if (CONJ != 0) begin
      sum_r = SW'(rr_i) + SW'(ii_i);
      sum_i = SW'(ri_i) - SW'(ir_i);
    end else begin
      sum_r = SW'(rr_i) - SW'(ii_i);
      sum_i = SW'(ri_i) + SW'(ir_i);
    end
    real_o = DATA_WIDTH'(narrow(dequantize(wide_t'(sum_r), FRAC_BITS), DATA_WIDTH,
                                SATURATE != 0));
    imag_o = DATA_WIDTH'(narrow(dequantize(wide_t'(sum_i), FRAC_BITS), DATA_WIDTH,
                                SATURATE != 0));
  end

endmodule

// File: rtl/demod_conj_mult.sv
// FM demodulator front end: pops a complex sample from paired real/imag
// FIFOs, multiplies it by the (conjugated) previous sample, dequantises,
// and pushes the result into paired output FIFOs. One sample per 3 cycles.
//   clock, reset               : rising-edge clock, synchronous active-high reset
//   inA_* / inB_*              : real / imag input FIFO (rd_en, empty, dout)
//   out_real_* / out_imag_*    : real / imag output FIFO (wr_en, full, din)
module demod_conj_mult
  import demod_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int CONJ       = 1,
  parameter int SATURATE   = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         inA_rd_en,
  input  logic                         inA_empty,
  input  logic signed [DATA_WIDTH-1:0] inA_dout,
  output logic                         inB_rd_en,
  input  logic                         inB_empty,
  input  logic signed [DATA_WIDTH-1:0] inB_dout,
  output logic                         out_real_wr_en,
  input  logic                         out_real_full,
  output logic signed [DATA_WIDTH-1:0] out_real_din,
  output logic                         out_imag_wr_en,
  input  logic                         out_imag_full,
  output logic signed [DATA_WIDTH-1:0] out_imag_din
);

  localparam int PW = 2 * DATA_WIDTH;

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] prev_r_q, prev_r_d, prev_i_q, prev_i_d;
  logic signed [DATA_WIDTH-1:0] cur_r_q, cur_r_d, cur_i_q, cur_i_d;
  logic signed [DATA_WIDTH-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
  logic signed [PW-1:0]         rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
  logic signed [DATA_WIDTH-1:0] res_r, res_i;
  logic                         pop, push;

  complex_mult_dequant #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .CONJ      (CONJ),
    .SATURATE  (SATURATE)
  ) u_cmd (
    .rr_i  (rr_q),
    .ii_i  (ii_q),
    .ri_i  (ri_q),
    .ir_i  (ir_q),
    .real_o(res_r),
    .imag_o(res_i)
  );

  always_comb begin
    state_d  = state_q;
    prev_r_d = prev_r_q;
    prev_i_d = prev_i_q;
    cur_r_d  = cur_r_q;
    cur_i_d  = cur_i_q;
    out_r_d  = out_r_q;
    out_i_d  = out_i_q;
    rr_d     = rr_q;
    ii_d     = ii_q;
    ri_d     = ri_q;
    ir_d     = ir_q;
    pop      = 1'b0;
    push     = 1'b0;
    case (state_q)
      S_READ: begin
        // Both halves of a sample must be present; never pop one FIFO alone.
        if (!reset && !inA_empty && !inB_empty) begin
          pop     = 1'b1;
          cur_r_d = inA_dout;
          cur_i_d = inB_dout;
          state_d = S_MULT;
        end
      end
      S_MULT: begin
        rr_d    = PW'(prev_r_q) * PW'(cur_r_q);
        ii_d    = PW'(prev_i_q) * PW'(cur_i_q);
        ri_d    = PW'(prev_r_q) * PW'(cur_i_q);
        ir_d    = PW'(prev_i_q) * PW'(cur_r_q);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // History advances only when the result actually leaves.
        if (!reset && !out_real_full && !out_imag_full) begin
          push     = 1'b1;
          out_r_d  = res_r;
          out_i_d  = res_i;
          prev_r_d = cur_r_q;
          prev_i_d = cur_i_q;
          state_d  = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_READ;
      prev_r_q <= '0;
      prev_i_q <= '0;
      cur_r_q  <= '0;
      cur_i_q  <= '0;
      out_r_q  <= '0;
      out_i_q  <= '0;
      rr_q     <= '0;
      ii_q     <= '0;
      ri_q     <= '0;
      ir_q     <= '0;
    end else begin
      state_q  <= state_d;
      prev_r_q <= prev_r_d;
      prev_i_q <= prev_i_d;
      cur_r_q  <= cur_r_d;
      cur_i_q  <= cur_i_d;
      out_r_q  <= out_r_d;
      out_i_q  <= out_i_d;
      rr_q     <= rr_d;
      ii_q     <= ii_d;
      ri_q     <= ri_d;
      ir_q     <= ir_d;
    end
  end

  assign inA_rd_en      = pop;
  assign inB_rd_en      = pop;
  assign out_real_wr_en = push;
  assign out_imag_wr_en = push;
  // din carries the fresh result in the write cycle, else the last written value.
  assign out_real_din   = push ? res_r : out_r_q;
  assign out_imag_din   = push ? res_i : out_i_q;

endmodule

// File: tb/tb_demod_conj_mult.sv
module tb_demod_conj_mult;

  typedef logic signed [127:0] w_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // DUT 0: defaults; DUT 1: CONJ=0; DUT 2: 16-bit saturate; DUT 3: 16-bit wrap
  logic [3:0] rd_a, rd_b, wr_r, wr_i, a_empty, b_empty, full_r, full_i;
  int a_dout[4];
  int b_dout[4];
  logic signed [31:0] r32[2];
  logic signed [31:0] i32[2];
  logic signed [15:0] r16[2];
  logic signed [15:0] i16[2];

  demod_conj_mult u_d0 (
    .clock(clock), .reset(reset),
    .inA_rd_en(rd_a[0]), .inA_empty(a_empty[0]), .inA_dout(a_dout[0]),
    .inB_rd_en(rd_b[0]), .inB_empty(b_empty[0]), .inB_dout(b_dout[0]),
    .out_real_wr_en(wr_r[0]), .out_real_full(full_r[0]), .out_real_din(r32[0]),
    .out_imag_wr_en(wr_i[0]), .out_imag_full(full_i[0]), .out_imag_din(i32[0]));

  demod_conj_mult #(.CONJ(0)) u_d1 (
    .clock(clock), .reset(reset),
    .inA_rd_en(rd_a[1]), .inA_empty(a_empty[1]), .inA_dout(a_dout[1]),
    .inB_rd_en(rd_b[1]), .inB_empty(b_empty[1]), .inB_dout(b_dout[1]),
    .out_real_wr_en(wr_r[1]), .out_real_full(full_r[1]), .out_real_din(r32[1]),
    .out_imag_wr_en(wr_i[1]), .out_imag_full(full_i[1]), .out_imag_din(i32[1]));

  demod_conj_mult #(.DATA_WIDTH(16), .SATURATE(1)) u_d2 (
    .clock(clock), .reset(reset),
    .inA_rd_en(rd_a[2]), .inA_empty(a_empty[2]), .inA_dout(a_dout[2][15:0]),
    .inB_rd_en(rd_b[2]), .inB_empty(b_empty[2]), .inB_dout(b_dout[2][15:0]),
    .out_real_wr_en(wr_r[2]), .out_real_full(full_r[2]), .out_real_din(r16[0]),
    .out_imag_wr_en(wr_i[2]), .out_imag_full(full_i[2]), .out_imag_din(i16[0]));

  demod_conj_mult #(.DATA_WIDTH(16), .SATURATE(0)) u_d3 (
    .clock(clock), .reset(reset),
    .inA_rd_en(rd_a[3]), .inA_empty(a_empty[3]), .inA_dout(a_dout[3][15:0]),
    .inB_rd_en(rd_b[3]), .inB_empty(b_empty[3]), .inB_dout(b_dout[3][15:0]),
    .out_real_wr_en(wr_r[3]), .out_real_full(full_r[3]), .out_real_din(r16[1]),
    .out_imag_wr_en(wr_i[3]), .out_imag_full(full_i[3]), .out_imag_din(i16[1]));

  int qa[4][$];
  int qb[4][$];
  int popped[4];
  int pops[4];
  int prev_r[4], prev_i[4], pend_r[4], pend_i[4], pop_cyc[4], last_r[4], last_i[4];
  bit pend_v[4];
  int log_r[4][$];
  int log_i[4][$];
  int log_c[4][$];
  int cyc;
  int n_checks;
  int n_fail;

  task automatic check_eq(input string name, input int k, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [dut%0d]: actual %0d, expected %0d", name, k, act, exp);
    end
  endtask

  function automatic int dout_r(input int k);
    case (k)
      0: return int'(r32[0]);
      1: return int'(r32[1]);
      2: return int'(r16[0]);
      default: return int'(r16[1]);
    endcase
  endfunction

  function automatic int dout_i(input int k);
    case (k)
      0: return int'(i32[0]);
      1: return int'(i32[1]);
      2: return int'(i16[0]);
      default: return int'(i16[1]);
    endcase
  endfunction

  // Fit a mathematically exact value into a dw-bit signed word.
  function automatic int fit(input w_t v_in, input int dw, input bit sat);
    w_t m;
    w_t half;
    w_t v;
    m    = w_t'(1) << dw;
    half = m / w_t'(2);
    v    = v_in;
    if (sat) begin
      if (v > half - w_t'(1)) return int'(half - w_t'(1));
      if (v < -half) return int'(-half);
      return int'(v);
    end
    v = v % m;
    if (v < 0) v = v + m;
    if (v >= half) v = v - m;
    return int'(v);
  endfunction

  // Complex product of cur with (conj) prev, divided by 1024 toward zero.
  function automatic void model(input int k, input int pr, input int pi,
                                input int cr, input int ci, output int er, output int ei);
    int dw;
    bit conj;
    bit sat;
    w_t re;
    w_t im;
    dw   = (k >= 2) ? 16 : 32;
    conj = (k != 1);
    sat  = (k == 2);
    if (conj) begin
      re = w_t'(pr) * w_t'(cr) + w_t'(pi) * w_t'(ci);
      im = w_t'(pr) * w_t'(ci) - w_t'(pi) * w_t'(cr);
    end else begin
      re = w_t'(pr) * w_t'(cr) - w_t'(pi) * w_t'(ci);
      im = w_t'(pr) * w_t'(ci) + w_t'(pi) * w_t'(cr);
    end
    er = fit(re / w_t'(1024), dw, sat);
    ei = fit(im / w_t'(1024), dw, sat);
  endfunction

  // Compare process: sampled on the falling edge, where every DUT output
  // reflects what the next rising edge will act on.
  always @(negedge clock) begin
    cyc++;
    for (int k = 0; k < 4; k++) begin
      int er, ei;
      check_eq("rd_en pair", k, rd_a[k], rd_b[k]);
      check_eq("wr_en pair", k, wr_r[k], wr_i[k]);
      if (reset) begin
        check_eq("rd_en in reset", k, rd_a[k], 0);
        check_eq("wr_en in reset", k, wr_r[k], 0);
        prev_r[k] = 0; prev_i[k] = 0; pend_v[k] = 0; last_r[k] = 0; last_i[k] = 0;
        continue;
      end
      if (rd_a[k]) begin
        check_eq("pop while empty or busy", k, int'(a_empty[k] | b_empty[k] | pend_v[k]), 0);
        if (!a_empty[k] && !b_empty[k]) begin
          pend_r[k] = qa[k][0]; pend_i[k] = qb[k][0];
          pend_v[k] = 1; pop_cyc[k] = cyc; pops[k]++;
        end
      end
      if (wr_r[k]) begin
        check_eq("write without sample", k, pend_v[k], 1);
        if (pend_v[k]) begin
          model(k, prev_r[k], prev_i[k], pend_r[k], pend_i[k], er, ei);
          check_eq("real din", k, dout_r(k), er);
          check_eq("imag din", k, dout_i(k), ei);
          check_eq("pop-to-push >= 2", k, int'(cyc - pop_cyc[k] >= 2), 1);
          log_r[k].push_back(dout_r(k)); log_i[k].push_back(dout_i(k)); log_c[k].push_back(cyc);
          prev_r[k] = pend_r[k]; prev_i[k] = pend_i[k]; pend_v[k] = 0;
          last_r[k] = er; last_i[k] = ei;
        end
      end else begin
        check_eq("real din hold", k, dout_r(k), last_r[k]);
        check_eq("imag din hold", k, dout_i(k), last_i[k]);
      end
    end
  end

  task automatic refresh();
    for (int k = 0; k < 4; k++) begin
      a_empty[k] = (qa[k].size() == 0);
      b_empty[k] = (qb[k].size() == 0);
      a_dout[k]  = a_empty[k] ? 0 : qa[k][0];
      b_dout[k]  = b_empty[k] ? 0 : qb[k][0];
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      for (int k = 0; k < 4; k++) begin
        while (popped[k] < pops[k]) begin
          void'(qa[k].pop_front());
          void'(qb[k].pop_front());
          popped[k]++;
        end
      end
      refresh();
    end
  endtask

  task automatic push(input int k, input int re, input int im);
    qa[k].push_back(re);
    qb[k].push_back(im);
    refresh();
  endtask

  initial begin
    int base;
    full_r = '0;
    full_i = '0;
    refresh();
    step(3);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("reset real din", k, dout_r(k), 0);
      check_eq("reset imag din", k, dout_i(k), 0);
      check_eq("reset wr_en", k, wr_r[k], 0);
      check_eq("reset rd_en", k, rd_a[k], 0);
    end

    // Basic rotation sequence on default parameters
    push(0, 1024, 0); push(0, 0, 1024); push(0, -1024, 0);
    step(15);
    check_eq("basic write count", 0, log_r[0].size(), 3);
    if (log_r[0].size() >= 3) begin
      check_eq("basic out0 real", 0, log_r[0][0], 0);
      check_eq("basic out0 imag", 0, log_i[0][0], 0);
      check_eq("basic out1 imag", 0, log_i[0][1], 1024);
      check_eq("basic out2 real", 0, log_r[0][2], 0);
      check_eq("basic out2 imag", 0, log_i[0][2], 1024);
      check_eq("unstalled spacing", 0, log_c[0][1] - log_c[0][0], 3);
    end

    // Truncation, plain multiply, 16-bit saturate and wrap
    push(0, 3, 0); push(0, -341, 0);
    push(1, 1024, 1024); push(1, 1024, 1024);
    push(2, 32767, 32767); push(2, 32767, 32767);
    push(3, 32767, 32767); push(3, 32767, 32767);
    step(12);
    check_eq("trunc write count", 0, log_r[0].size(), 5);
    if (log_r[0].size() >= 5) begin
      check_eq("trunc -3072 real", 0, log_r[0][3], -3);
      check_eq("trunc -1023 real", 0, log_r[0][4], 0);
    end
    check_eq("conj0 write count", 1, log_r[1].size(), 2);
    if (log_r[1].size() >= 2) begin
      check_eq("conj0 real", 1, log_r[1][1], 0);
      check_eq("conj0 imag", 1, log_i[1][1], 2048);
    end
    check_eq("sat write count", 2, log_r[2].size(), 2);
    if (log_r[2].size() >= 2) begin
      check_eq("sat real", 2, log_r[2][1], 32767);
      check_eq("sat imag", 2, log_i[2][1], 0);
    end
    check_eq("wrap write count", 3, log_r[3].size(), 2);
    if (log_r[3].size() >= 2) begin
      check_eq("wrap real", 3, log_r[3][1], -128);
      check_eq("wrap imag", 3, log_i[3][1], 0);
    end

    // Backpressure: imag output full while a result is pending
    full_i[0] = 1'b1;
    push(0, 2048, 0); push(0, 0, 2048);
    step(8);
    check_eq("stall no write", 0, log_r[0].size(), 5);
    check_eq("stall no pop", 0, qa[0].size(), 1);
    full_i[0] = 1'b0;
    step(1);
    check_eq("release one write", 0, log_r[0].size(), 6);
    check_eq("release no early pop", 0, qa[0].size(), 1);
    if (log_r[0].size() >= 6) check_eq("stalled value", 0, log_r[0][5], -682);
    step(1);
    check_eq("pop after release", 0, qa[0].size(), 0);
    step(4);
    check_eq("post-stall write count", 0, log_r[0].size(), 7);

    // Input skew: real FIFO has data, imag FIFO empty
    base = pops[0];
    qa[0].push_back(1024);
    refresh();
    step(4);
    check_eq("skew no pop", 0, pops[0] - base, 0);
    check_eq("skew real kept", 0, qa[0].size(), 1);
    qb[0].push_back(0);
    refresh();
    step(1);
    check_eq("skew joint pop", 0, pops[0] - base, 1);
    step(4);
    check_eq("skew write count", 0, log_r[0].size(), 8);

    // Reset while the sample sits in S_MULT
    base = pops[0];
    push(0, 100, 200);
    step(1);
    check_eq("mid-reset pop taken", 0, pops[0] - base, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("post-reset rd_en", 0, rd_a[0], 0);
    check_eq("post-reset wr_en real", 0, wr_r[0], 0);
    check_eq("post-reset wr_en imag", 0, wr_i[0], 0);
    check_eq("post-reset real din", 0, dout_r(0), 0);
    step(3);
    check_eq("discarded sample", 0, log_r[0].size(), 8);
    push(0, 500, 500);
    step(5);
    check_eq("after-reset write count", 0, log_r[0].size(), 9);
    if (log_r[0].size() >= 9) begin
      check_eq("cleared history real", 0, log_r[0][8], 0);
      check_eq("cleared history imag", 0, log_i[0][8], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
